// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - shift-and-add multiplier sequencing a shared ALU (option: ALU_MULT_EARLY_EXIT_EN)
module alu_mult_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_fs,
  input  logic [WIDTH-1:0] alu_f,
  input  logic [3:0]       alu_status
);

  localparam logic [4:0] FS_NOP = 5'b00000;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SHL = 5'b10000;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHL, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CNT_W-1:0] cnt;
  logic             ovf_reg;

  logic [WIDTH-1:0] q_next;
  logic             last_iter;
  logic             shl_exit;
  state_t           accept_state;
  logic             carry;

  assign q_next    = q_reg >> 1;
  assign last_iter = (cnt == LAST_CNT);
  assign carry     = alu_status[2];

`ifdef ALU_MULT_EARLY_EXIT_EN
  // Stop as soon as no multiplier bits remain; a zero multiplier skips the loop.
  assign shl_exit     = last_iter || (q_next == '0);
  assign accept_state = (op_b == '0) ? DONE : (op_b[0] ? ADD : SHL);
`else
  assign shl_exit     = last_iter;
  assign accept_state = op_b[0] ? ADD : SHL;
`endif

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign product = p_reg;
  assign ovf     = ovf_reg;

  // ALU operands are decoded from the current state; the result returns in the same cycle.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fs = FS_NOP;
    case (state)
      ADD: begin
        alu_a  = p_reg;
        alu_b  = m_reg;
        alu_fs = FS_ADD;
      end
      SHL: begin
        alu_a  = m_reg;
        alu_b  = WIDTH'(1);
        alu_fs = FS_SHL;
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_fs = FS_NOP;
      end
    endcase
  end

  // Sequencer: accept operands, alternate ADD/SHL per multiplier bit, pulse DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      p_reg   <= '0;
      m_reg   <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      ovf_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p_reg   <= '0;
            m_reg   <= op_a;
            q_reg   <= op_b;
            cnt     <= '0;
            ovf_reg <= 1'b0;
            state   <= accept_state;
          end
        end
        ADD: begin
          p_reg <= alu_f;
          if (carry) ovf_reg <= 1'b1;
          state <= SHL;
        end
        SHL: begin
          m_reg <= alu_f;
          q_reg <= q_next;
          cnt   <= cnt + CNT_W'(1);
          // A multiplicand bit shifted out still carries weight if multiplier bits remain.
          if (m_reg[WIDTH-1] && (q_next != '0)) ovf_reg <= 1'b1;
          if (shl_exit)       state <= DONE;
          else if (q_next[0]) state <= ADD;
          else                state <= SHL;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb/tb_alu_mult_sequencer.sv - directed-vector bench for alu_mult_sequencer with a behavioural ALU
module tb_alu_mult_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] op_a  = '0;
  logic [63:0] op_b  = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        ovf;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [4:0]  alu_fs;
  logic [63:0] alu_f;
  logic [3:0]  alu_status;

  int checks = 0;
  int errors = 0;

  alu_mult_sequencer #(.WIDTH(64), .CNT_W(7)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .ovf        (ovf),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fs     (alu_fs),
    .alu_f      (alu_f),
    .alu_status (alu_status)
  );

  always #5 clock = ~clock;

  // Shared ALU: ADD with carry out on status[2], shift-left by B[5:0].
  logic [64:0] sum;
  always_comb begin
    sum        = {1'b0, alu_a} + {1'b0, alu_b};
    alu_f      = '0;
    alu_status = '0;
    case (alu_fs)
      5'b01000: begin
        alu_f      = sum[63:0];
        alu_status = {1'b0, sum[64], sum[63], sum[63:0] == '0};
      end
      5'b10000: begin
        alu_f      = alu_a << alu_b[5:0];
        alu_status = {1'b0, 1'b0, alu_f[63], alu_f == '0};
      end
      default: begin
        alu_f      = '0;
        alu_status = '0;
      end
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [4:0] fs_seen [1:5];

  // Runs one multiply starting in the current (IDLE) cycle; returns in the cycle after DONE.
  task automatic do_mult(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_p, input logic exp_o, input int exp_cyc,
                         input int glitch_cyc);
    int cyc;
    int done_cnt;
    int done_cyc;
    logic busy_after;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clock);
    cyc        = 1;
    done_cnt   = 0;
    done_cyc   = -1;
    busy_after = 1'b1;
    while (cyc < 300) begin
      if (cyc == glitch_cyc) begin
        start = 1'b1;
        op_a  = ~a;
        op_b  = b + 64'd1;
      end else begin
        start = 1'b0;
      end
      if (cyc <= 5) fs_seen[cyc] = alu_fs;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check_eq({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    check_eq({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_busy_after"}, 64'(busy_after), 64'd0);
    check_eq({tag, "_product"}, product, exp_p);
    check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp_o));
  endtask

  int rst_done;

  initial begin
    repeat (3) @(negedge clock);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_product", product, 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_alu_a", alu_a, 64'd0);
    check_eq("rst_alu_b", alu_b, 64'd0);
    check_eq("rst_alu_fs", 64'(alu_fs), 64'd0);
    reset = 1'b0;
    @(negedge clock);

`ifdef ALU_MULT_EARLY_EXIT_EN
    do_mult("basic_3x5", 64'd3, 64'd5, 64'd15, 1'b0, 6, 0);
`else
    do_mult("basic_3x5", 64'd3, 64'd5, 64'd15, 1'b0, 67, 0);
`endif
    check_eq("fs_c1", 64'(fs_seen[1]), 64'(5'b01000));
    check_eq("fs_c2", 64'(fs_seen[2]), 64'(5'b10000));
    check_eq("fs_c3", 64'(fs_seen[3]), 64'(5'b10000));
    check_eq("fs_c4", 64'(fs_seen[4]), 64'(5'b01000));
    check_eq("fs_c5", 64'(fs_seen[5]), 64'(5'b10000));

    // Back-to-back: previous product holds in IDLE up to the new accept edge.
    check_eq("b2b_hold", product, 64'd15);
`ifdef ALU_MULT_EARLY_EXIT_EN
    do_mult("b2b_6x7", 64'd6, 64'd7, 64'd42, 1'b0, 7, 0);
    do_mult("zero_b", 64'd3, 64'd0, 64'd0, 1'b0, 1, 0);
    do_mult("ovf_shift", 64'h8000000000000000, 64'd2, 64'd0, 1'b1, 4, 0);
    do_mult("ones_sq", '1, '1, 64'd1, 1'b1, 129, 0);
    do_mult("restart_ign", 64'd5, 64'h0F00, 64'h4B00, 1'b0, 17, 10);
`else
    do_mult("b2b_6x7", 64'd6, 64'd7, 64'd42, 1'b0, 68, 0);
    do_mult("zero_b", 64'd3, 64'd0, 64'd0, 1'b0, 65, 0);
    do_mult("ovf_shift", 64'h8000000000000000, 64'd2, 64'd0, 1'b1, 66, 0);
    do_mult("ones_sq", '1, '1, 64'd1, 1'b1, 129, 0);
    do_mult("restart_ign", 64'd5, 64'h0F00, 64'h4B00, 1'b0, 69, 10);
`endif

    // Reset in cycle 4 of a 7*9 multiply aborts it with no done pulse.
    rst_done = 0;
    start = 1'b1;
    op_a  = 64'd7;
    op_b  = 64'd9;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) rst_done++;
      reset = (c == 4);
    end
    reset = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_product", product, 64'd0);
    check_eq("abort_ovf", 64'(ovf), 64'd0);
    check_eq("abort_no_done", 64'(rst_done), 64'd0);
`ifdef ALU_MULT_EARLY_EXIT_EN
    do_mult("after_abort", 64'd7, 64'd9, 64'd63, 1'b0, 7, 0);
`else
    do_mult("after_abort", 64'd7, 64'd9, 64'd63, 1'b0, 67, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
